// File: rtl/apes_stim_pkg.sv
// ----------------------------------------------------------------------------
// apes_stim_pkg : shared state encoding and timing constants for stim_sequencer
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none
`timescale 1ns/1ps

package apes_stim_pkg;

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_RUN  = 3'd1;
  localparam logic [2:0] ST_TAIL = 3'd2;
  localparam logic [2:0] ST_GAP  = 3'd3;
  localparam logic [2:0] ST_FIN  = 3'd4;

  typedef enum logic [2:0] {
    S_IDLE = ST_IDLE,
    S_RUN  = ST_RUN,
    S_TAIL = ST_TAIL,
    S_GAP  = ST_GAP,
    S_FIN  = ST_FIN
  } stim_state_e;

  localparam int DEF_TO_CYCLES = 600;

  // Test-pulse repetition period; the timeout must be longer than this.
  localparam int STIM_PERIOD = 256;

endpackage

`default_nettype wire

// File: rtl/stim_edge_timer.sv
// ----------------------------------------------------------------------------
// stim_edge_timer : stim_fb rise detector and saturating no-edge timeout counter
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none
`timescale 1ns/1ps

module stim_edge_timer
  import apes_stim_pkg::*;
#(
  parameter int TO_CYCLES = DEF_TO_CYCLES
) (
  input  logic clk50,
  input  logic rst_n,
  input  logic fb_i,
  input  logic en_i,
  output logic rise_o,
  output logic expired_o
);

  localparam int              TW      = $clog2(TO_CYCLES + 1);
  localparam logic [TW-1:0]   TO_MAX  = TW'(TO_CYCLES);
  localparam logic [TW-1:0]   TO_LAST = TW'(TO_CYCLES - 1);
  localparam logic [TW-1:0]   ONE     = TW'(1);

  logic          fb_q;
  logic [TW-1:0] cnt_q;
  logic [TW-1:0] cnt_d;

  assign rise_o = fb_i & ~fb_q;

  always_comb begin
    cnt_d = cnt_q;
    if (!en_i || rise_o) begin
      cnt_d = '0;
    end else if (cnt_q != TO_MAX) begin
      cnt_d = cnt_q + ONE;
    end
  end

  // Fires on the clock that completes TO_CYCLES edge-free clocks while enabled.
  assign expired_o = en_i & ~rise_o & (cnt_q >= TO_LAST);

  always_ff @(posedge clk50 or negedge rst_n) begin
    if (!rst_n) begin
      fb_q  <= 1'b0;
      cnt_q <= '0;
    end else begin
      fb_q  <= fb_i;
      cnt_q <= cnt_d;
    end
  end

endmodule

`default_nettype wire

// File: rtl/stim_sequencer.sv
// ----------------------------------------------------------------------------
// stim_sequencer : burst/run controller for the ASIC test-pulse generator
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none
`timescale 1ns/1ps

module stim_sequencer
  import apes_stim_pkg::*;
#(
  parameter int CNT_W     = 16,
  parameter int BURST_W   = 8,
  parameter int TO_CYCLES = DEF_TO_CYCLES
) (
  input  logic               clk50,
  input  logic               rst_n,
  input  logic               start,
  input  logic               abort,
  input  logic [CNT_W-1:0]   cfg_pulses,
  input  logic [CNT_W-1:0]   cfg_gap,
  input  logic [BURST_W-1:0] cfg_bursts,
  input  logic               stim_fb,
  output logic               stim_en,
  output logic               busy,
  output logic               done,
  output logic               aborted,
  output logic               timeout_err,
  output logic [CNT_W-1:0]   pulse_cnt,
  output logic [BURST_W-1:0] burst_cnt
);

  localparam logic [CNT_W-1:0]   CNT_ONE   = CNT_W'(1);
  localparam logic [BURST_W-1:0] BURST_ONE = BURST_W'(1);

  stim_state_e        state_q,       state_d;
  logic [CNT_W-1:0]   pulses_q,      pulses_d;
  logic [CNT_W-1:0]   gap_cfg_q,     gap_cfg_d;
  logic [BURST_W-1:0] bursts_q,      bursts_d;
  logic [CNT_W-1:0]   pulse_cnt_q,   pulse_cnt_d;
  logic [BURST_W-1:0] burst_cnt_q,   burst_cnt_d;
  logic [CNT_W-1:0]   gap_cnt_q,     gap_cnt_d;
  logic               timeout_err_q, timeout_err_d;
  logic               done_q,        done_d;
  logic               aborted_q,     aborted_d;

  logic w_run;
  logic w_rise;
  logic w_expired;

  assign w_run = (state_q == S_RUN);

  stim_edge_timer #(
    .TO_CYCLES (TO_CYCLES)
  ) u_edge_timer (
    .clk50     (clk50),
    .rst_n     (rst_n),
    .fb_i      (stim_fb),
    .en_i      (w_run),
    .rise_o    (w_rise),
    .expired_o (w_expired)
  );

  always_comb begin
    state_d       = state_q;
    pulses_d      = pulses_q;
    gap_cfg_d     = gap_cfg_q;
    bursts_d      = bursts_q;
    pulse_cnt_d   = pulse_cnt_q;
    burst_cnt_d   = burst_cnt_q;
    gap_cnt_d     = gap_cnt_q;
    timeout_err_d = timeout_err_q;
    done_d        = 1'b0;
    aborted_d     = 1'b0;

    // Abort outranks everything, including a burst finishing on the same clock.
    if (abort && (state_q != S_IDLE)) begin
      state_d   = S_IDLE;
      aborted_d = 1'b1;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start && !abort) begin
            pulses_d      = cfg_pulses;
            gap_cfg_d     = cfg_gap;
            bursts_d      = cfg_bursts;
            pulse_cnt_d   = '0;
            burst_cnt_d   = '0;
            gap_cnt_d     = '0;
            timeout_err_d = 1'b0;
            if ((cfg_pulses == '0) || (cfg_bursts == '0)) begin
              state_d = S_FIN;
            end else begin
              state_d = S_RUN;
            end
          end
        end

        S_RUN: begin
          if (w_rise) begin
            pulse_cnt_d = pulse_cnt_q + CNT_ONE;
            if (pulse_cnt_q == (pulses_q - CNT_ONE)) begin
              state_d = S_TAIL;
            end
          end else if (w_expired) begin
            state_d       = S_IDLE;
            timeout_err_d = 1'b1;
            aborted_d     = 1'b1;
          end
        end

        S_TAIL: begin
          if (!stim_fb) begin
            burst_cnt_d = burst_cnt_q + BURST_ONE;
            if ((burst_cnt_q + BURST_ONE) == bursts_q) begin
              state_d = S_FIN;
            end else begin
              state_d   = S_GAP;
              gap_cnt_d = gap_cfg_q;
            end
          end
        end

        S_GAP: begin
          if (gap_cnt_q == '0) begin
            pulse_cnt_d = '0;
            state_d     = S_RUN;
          end else begin
            gap_cnt_d = gap_cnt_q - CNT_ONE;
          end
        end

        // Two clocks: the first arms done, the second shows it and leaves.
        S_FIN: begin
          if (done_q) begin
            state_d = S_IDLE;
          end else begin
            done_d = 1'b1;
          end
        end

        default: begin
          state_d = S_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk50 or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      pulses_q      <= '0;
      gap_cfg_q     <= '0;
      bursts_q      <= '0;
      pulse_cnt_q   <= '0;
      burst_cnt_q   <= '0;
      gap_cnt_q     <= '0;
      timeout_err_q <= 1'b0;
      done_q        <= 1'b0;
      aborted_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      pulses_q      <= pulses_d;
      gap_cfg_q     <= gap_cfg_d;
      bursts_q      <= bursts_d;
      pulse_cnt_q   <= pulse_cnt_d;
      burst_cnt_q   <= burst_cnt_d;
      gap_cnt_q     <= gap_cnt_d;
      timeout_err_q <= timeout_err_d;
      done_q        <= done_d;
      aborted_q     <= aborted_d;
    end
  end

  // Decoded from state so an asynchronous reset drops stim_en without a clock.
  assign stim_en     = (state_q == S_RUN) || (state_q == S_TAIL);
  assign busy        = (state_q != S_IDLE);
  assign done        = done_q;
  assign aborted     = aborted_q;
  assign timeout_err = timeout_err_q;
  assign pulse_cnt   = pulse_cnt_q;
  assign burst_cnt   = burst_cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_stim_sequencer.sv
// ----------------------------------------------------------------------------
// tb_stim_sequencer : directed scoreboard bench for stim_sequencer
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none
`timescale 1ns/1ps

module tb_stim_sequencer;

  localparam int CNT_W     = 16;
  localparam int BURST_W   = 8;
  localparam int TO_CYCLES = 600;

  logic               clk50      = 1'b0;
  logic               rst_n      = 1'b0;
  logic               start      = 1'b0;
  logic               abort      = 1'b0;
  logic [CNT_W-1:0]   cfg_pulses = '0;
  logic [CNT_W-1:0]   cfg_gap    = '0;
  logic [BURST_W-1:0] cfg_bursts = '0;
  logic               stim_fb    = 1'b0;
  logic               stim_en;
  logic               busy;
  logic               done;
  logic               aborted;
  logic               timeout_err;
  logic [CNT_W-1:0]   pulse_cnt;
  logic [BURST_W-1:0] burst_cnt;

  stim_sequencer #(
    .CNT_W     (CNT_W),
    .BURST_W   (BURST_W),
    .TO_CYCLES (TO_CYCLES)
  ) dut (
    .clk50       (clk50),
    .rst_n       (rst_n),
    .start       (start),
    .abort       (abort),
    .cfg_pulses  (cfg_pulses),
    .cfg_gap     (cfg_gap),
    .cfg_bursts  (cfg_bursts),
    .stim_fb     (stim_fb),
    .stim_en     (stim_en),
    .busy        (busy),
    .done        (done),
    .aborted     (aborted),
    .timeout_err (timeout_err),
    .pulse_cnt   (pulse_cnt),
    .burst_cnt   (burst_cnt)
  );

  always #10 clk50 = ~clk50;

  // Test-pulse stage: 256-clock period, 64-clock high pulse, phase restarts when disabled.
  logic [7:0] ph     = 8'd0;
  logic       fb_tie0 = 1'b0;
  always @(posedge clk50) begin
    if (!stim_en) ph <= 8'd0;
    else          ph <= ph + 8'd1;
    stim_fb <= stim_en && !fb_tie0 && (ph >= 8'd8) && (ph < 8'd72);
  end

  int n_cmp  = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  // Scoreboard of end-of-run status pulses.
  typedef struct packed {
    logic               d;
    logic               a;
    logic               t;
    logic [CNT_W-1:0]   pc;
    logic [BURST_W-1:0] bc;
  } exp_t;
  exp_t exp_q[$];

  always @(negedge clk50) begin
    if (rst_n && (done || aborted)) begin
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL status_unexpected: got done=%0b aborted=%0b, expected no status pulse", done, aborted);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        if ({done, aborted, timeout_err, pulse_cnt, burst_cnt} !== e) begin
          n_fail++;
          $display("FAIL status: got done=%0b aborted=%0b timeout_err=%0b pulse_cnt=%0d burst_cnt=%0d, expected %0b %0b %0b %0d %0d",
                   done, aborted, timeout_err, pulse_cnt, burst_cnt, e.d, e.a, e.t, e.pc, e.bc);
        end
      end
    end
  end

  // Activity statistics and per-event records for the directed tests.
  int         en_cyc   = 0;
  int         busy_cyc = 0;
  int         rise_cyc = 0;
  int         low_run  = 0;
  logic       prev_fb  = 1'b0;
  logic       prev2_fb = 1'b0;
  logic       prev_en  = 1'b0;
  int         gap_q[$];
  logic [1:0] tail_q[$];

  always @(negedge clk50) begin
    if (stim_en)               en_cyc   <= en_cyc + 1;
    if (busy)                  busy_cyc <= busy_cyc + 1;
    if (stim_fb && !prev_fb)   rise_cyc <= rise_cyc + 1;
    low_run <= (busy && !stim_en) ? low_run + 1 : 0;
    if (busy && stim_en && !prev_en && (low_run > 0)) gap_q.push_back(low_run);
    if (busy && prev_en && !stim_en) tail_q.push_back({prev2_fb, prev_fb});
    prev2_fb <= prev_fb;
    prev_fb  <= stim_fb;
    prev_en  <= stim_en;
  end

  task automatic tick();
    @(posedge clk50);
    #1;
  endtask

  task automatic go(input int p, input int g, input int b);
    cfg_pulses = CNT_W'(p);
    cfg_gap    = CNT_W'(g);
    cfg_bursts = BURST_W'(b);
    start      = 1'b1;
    tick();
    start      = 1'b0;
  endtask

  task automatic push_exp(input logic d, input logic a, input logic t, input int pc, input int bc);
    exp_t e;
    e.d  = d;
    e.a  = a;
    e.t  = t;
    e.pc = CNT_W'(pc);
    e.bc = BURST_W'(bc);
    exp_q.push_back(e);
  endtask

  task automatic wait_idle(input int budget);
    int n;
    n = 0;
    while (busy && (n < budget)) begin
      @(negedge clk50);
      n++;
    end
    check("idle_within_budget", 32'(busy), 32'd0);
  endtask

  // mode 0: inside a feedback pulse at (pc,bc); mode 1: in tail with stim_fb just low.
  task automatic wait_point(input int mode, input int pc, input int bc, input int budget);
    int   n;
    logic hit;
    n   = 0;
    hit = 1'b0;
    while (!hit && (n < budget)) begin
      @(negedge clk50);
      n++;
      if (mode == 0) hit = stim_fb && (int'(pulse_cnt) == pc) && (int'(burst_cnt) == bc);
      else           hit = stim_en && !stim_fb && (int'(pulse_cnt) == pc);
    end
    check("reach_point", 32'(hit), 32'd1);
  endtask

  task automatic check_tails(input int n_exp);
    check("tail_count", 32'(tail_q.size()), 32'(n_exp));
    foreach (tail_q[i]) check("tail_drop_after_fb_fall", 32'(tail_q[i]), 32'b10);
    tail_q.delete();
  endtask

  task automatic check_idle_outputs(input string name);
    check(name, {23'd0, stim_en, busy, done, aborted, timeout_err, 2'b00, 1'b0, 1'b0},
          32'd0);
    check({name, "_cnt"}, {8'd0, pulse_cnt, burst_cnt}, 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation still running at 1 ms, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int r0;
    int e0;
    int b0;

    repeat (3) @(negedge clk50);
    check_idle_outputs("reset_state");
    rst_n = 1'b1;
    repeat (2) @(negedge clk50);

    // Single burst of three pulses.
    gap_q.delete(); tail_q.delete();
    r0 = rise_cyc;
    push_exp(1'b1, 1'b0, 1'b0, 3, 1);
    cfg_pulses = 16'd3; cfg_bursts = 8'd1; cfg_gap = 16'd0;
    check("en_before_start", 32'(stim_en), 32'd0);
    go(3, 0, 1);
    check("en_after_start", 32'(stim_en), 32'd1);
    wait_idle(3000);
    check("rises_burst1", 32'(rise_cyc - r0), 32'd3);
    check_tails(1);
    tick();

    // Three bursts of two pulses with a gap of 10.
    gap_q.delete(); tail_q.delete();
    r0 = rise_cyc;
    push_exp(1'b1, 1'b0, 1'b0, 2, 3);
    go(2, 10, 3);
    wait_idle(5000);
    check("rises_3x2", 32'(rise_cyc - r0), 32'd6);
    check("gap_count", 32'(gap_q.size()), 32'd2);
    foreach (gap_q[i]) check("gap_low_clocks", 32'(gap_q[i]), 32'd11);
    check_tails(3);
    tick();

    // Zero pulses: immediate finish.
    e0 = en_cyc; b0 = busy_cyc;
    push_exp(1'b1, 1'b0, 1'b0, 0, 0);
    go(0, 0, 5);
    wait_idle(50);
    check("zero_busy_cycles", 32'(busy_cyc - b0), 32'd2);
    check("zero_en_cycles", 32'(en_cyc - e0), 32'd0);
    tick();

    // No feedback: timeout.
    fb_tie0 = 1'b1;
    e0 = en_cyc;
    push_exp(1'b0, 1'b1, 1'b1, 0, 0);
    go(4, 0, 1);
    wait_idle(2000);
    check("timeout_en_cycles", 32'(en_cyc - e0), 32'd600);
    check("timeout_en_low", 32'(stim_en), 32'd0);
    check("timeout_err_set", 32'(timeout_err), 32'd1);
    fb_tie0 = 1'b0;
    tick();
    push_exp(1'b1, 1'b0, 1'b0, 0, 0);
    go(0, 0, 1);
    check("timeout_err_cleared", 32'(timeout_err), 32'd0);
    wait_idle(50);
    tick();

    // Start during RUN ignored, then abort inside pulse 2 of burst 2.
    push_exp(1'b0, 1'b1, 1'b0, 2, 1);
    go(3, 5, 2);
    wait_point(0, 1, 0, 2000);
    cfg_pulses = 16'd7;
    start = 1'b1;
    tick();
    start = 1'b0;
    check("start_in_run_pulse_cnt", 32'(pulse_cnt), 32'd1);
    check("start_in_run_busy", 32'(busy), 32'd1);
    wait_point(0, 2, 1, 3000);
    repeat (20) @(negedge clk50);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("abort_mid_busy", 32'(busy), 32'd0);
    check("abort_mid_en", 32'(stim_en), 32'd0);
    check("abort_mid_flags", {30'd0, aborted, done}, 32'b10);
    tick();

    // Abort on the clock that the final tail completes.
    tail_q.delete();
    push_exp(1'b0, 1'b1, 1'b0, 1, 0);
    go(1, 0, 1);
    wait_point(1, 1, 0, 2000);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("abort_tail_busy", 32'(busy), 32'd0);
    check("abort_tail_en", 32'(stim_en), 32'd0);
    check("abort_tail_flags", {30'd0, aborted, done}, 32'b10);
    check("abort_tail_burst_cnt", 32'(burst_cnt), 32'd0);
    tick();

    // Asynchronous reset mid-run.
    go(3, 0, 1);
    repeat (30) @(negedge clk50);
    check("en_before_reset", 32'(stim_en), 32'd1);
    #3;
    rst_n = 1'b0;
    #1;
    check("en_async_reset", 32'(stim_en), 32'd0);
    repeat (3) @(negedge clk50);
    rst_n = 1'b1;
    @(negedge clk50);
    check_idle_outputs("after_reset");
    push_exp(1'b1, 1'b0, 1'b0, 1, 1);
    go(1, 0, 1);
    check("en_after_reset_start", 32'(stim_en), 32'd1);
    wait_idle(2000);

    repeat (3) @(negedge clk50);
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
